// File: rtl/display_scan4_if.sv
// Bundle of the data/strobe inputs and scan outputs of display_scan4.
// The master side drives the data and load strobe. The slave side (the scanner) drives the display outputs.
interface display_scan4_if;
    logic [15:0] data_in;
    logic        load;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic        frame_tick;
    logic        pending;

    modport master (
        output data_in, load,
        input  bcd, an, digit_sel, frame_tick, pending
    );

    modport slave (
        input  data_in, load,
        output bcd, an, digit_sel, frame_tick, pending
    );
endinterface

// File: rtl/display_scan4.sv
// 4-digit multiplexed display scanner; loads are shadowed and committed on frame wrap (LEAD_ZERO_BLANK_EN: blank leading zeros).
// Latency: load visible within 4*CLK_DIV+1 cycles; no backpressure, a later load simply overwrites the shadow.
module display_scan4 #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst,
    display_scan4_if.slave  bus
);
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [15:0]   display_q, display_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic [3:0]    bcd_q, bcd_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q;
    logic          advance;
    logic          wrap;

    always_comb begin
        advance   = (presc_q == TC);
        wrap      = advance && (digit_q == 2'd3);
        presc_d   = advance ? '0 : presc_q + 1'b1;
        digit_d   = advance ? digit_q + 2'd1 : digit_q;
        display_d = display_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;

        // A load coinciding with the wrap bypasses the shadow so it is never stale.
        if (wrap) begin
            if (bus.load) begin
                display_d = bus.data_in;
                shadow_d  = bus.data_in;
            end else if (pending_q) begin
                display_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            shadow_d  = bus.data_in;
            pending_d = 1'b1;
        end

        bcd_d = display_d[{digit_d, 2'b00} +: 4];
        an_d  = ~(4'b0001 << digit_d);
`ifdef LEAD_ZERO_BLANK_EN
        case (digit_d)
            2'd1:    if (display_d[15:4] == 12'h000) an_d = 4'b1111;
            2'd2:    if (display_d[15:8] == 8'h00)   an_d = 4'b1111;
            2'd3:    if (display_d[15:12] == 4'h0)   an_d = 4'b1111;
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            digit_q   <= 2'd0;
            display_q <= 16'h0000;
            shadow_q  <= 16'h0000;
            pending_q <= 1'b0;
            bcd_q     <= 4'h0;
            an_q      <= 4'b1110;
            tick_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            digit_q   <= digit_d;
            display_q <= display_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            bcd_q     <= bcd_d;
            an_q      <= an_d;
            tick_q    <= wrap;
        end
    end

    assign bus.bcd        = bcd_q;
    assign bus.an         = an_q;
    assign bus.digit_sel  = digit_q;
    assign bus.frame_tick = tick_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_display_scan4.sv
// Randomized bench for display_scan4 against a cycle-count based model of the scan and commit rules.
module tb_display_scan4;
    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_scan4_if bus ();

    display_scan4 #(.CLK_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          t        = 0;   // clock edges since reset release
    logic [15:0] m_disp   = 16'h0;
    logic [15:0] m_sh     = 16'h0;
    logic        m_pend   = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [3:0] exp_an(input int dg);
        logic [3:0] a;
        a     = 4'b1111;
        a[dg] = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        if (dg > 0 && (m_disp >> (4 * dg)) == 16'h0) a = 4'b1111;
`endif
        return a;
    endfunction

    task automatic check_all();
        int dg;
        dg = (t / DIV) % 4;
        chk("digit_sel", 16'(bus.digit_sel), 16'(dg));
        chk("bcd", 16'(bus.bcd), 16'((m_disp >> (4 * dg)) & 16'hF));
        chk("an", 16'(bus.an), 16'(exp_an(dg)));
        chk("frame_tick", 16'(bus.frame_tick), 16'(t > 0 && (t % FRAME) == 0));
        chk("pending", 16'(bus.pending), 16'(m_pend));
    endtask

    task automatic model_edge(input logic ld, input logic [15:0] d);
        if (((t + 1) % FRAME) == 0) begin
            if (ld) begin
                m_disp = d;
                m_pend = 1'b0;
            end else if (m_pend) begin
                m_disp = m_sh;
                m_pend = 1'b0;
            end
        end else if (ld) begin
            m_sh   = d;
            m_pend = 1'b1;
        end
        t++;
    endtask

    // Called at a falling edge; applies inputs for one rising edge and checks the result.
    task automatic cycle(input logic ld, input logic [15:0] d);
        bus.load    = ld;
        bus.data_in = d;
        @(posedge clk);
        model_edge(ld, d);
        @(negedge clk);
        bus.load    = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0);
    endtask

    task automatic run_to_phase(input int p);
        for (int i = 0; i < FRAME && (t % FRAME) != p; i++) cycle(1'b0, 16'h0);
    endtask

    task automatic do_reset(input int hold);
        rst         = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = 16'h0;
        t      = 0;
        m_disp = 16'h0;
        m_sh   = 16'h0;
        m_pend = 1'b0;
        #1;
        check_all();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
        rst = 1'b1;
    endtask

    initial begin
        bus.load    = 1'b0;
        bus.data_in = 16'h0;
        @(negedge clk);
        do_reset(2);

        // Idle scan: anodes rotate, bcd stays 0, frame_tick every frame.
        idle(2 * FRAME + 3);

        // Mid-frame load is held pending until the wrap.
        run_to_phase(5);
        cycle(1'b1, 16'h1234);
        chk("pending_after_load", 16'(bus.pending), 16'h1);
        idle(2 * FRAME);

        // Two loads in one frame: only the latest is committed.
        run_to_phase(2);
        cycle(1'b1, 16'hAAAA);
        cycle(1'b0, 16'h0);
        cycle(1'b1, 16'h5678);
        idle(2 * FRAME);

        // Load in the wrap cycle commits directly.
        run_to_phase(FRAME - 1);
        cycle(1'b1, 16'h9876);
        chk("wrap_load_bcd", 16'(bus.bcd), 16'h0006);
        chk("wrap_load_pending", 16'(bus.pending), 16'h0);
        idle(FRAME + 2);

        // Reset during digit 2 with a pending value discards it.
        run_to_phase(1);
        cycle(1'b1, 16'hBEEF);
        run_to_phase(2 * DIV + 1);
        @(negedge clk);
        t++;  // the idle edge just consumed by the extra negedge wait
        do_reset(1);
        chk("rst_an", 16'(bus.an), 16'h000E);
        chk("rst_pending", 16'(bus.pending), 16'h0);
        cycle(1'b1, 16'h4321);  // load right after release
        idle(2 * FRAME);

        // Leading-zero pattern.
        run_to_phase(3);
        cycle(1'b1, 16'h0050);
        idle(2 * FRAME);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                @(negedge clk);
                do_reset(1);
            end else begin
                cycle(($urandom_range(0, 5) == 0), 16'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/display_scan4.md
DISPLAY_SCAN4 -- requirements
Module: display_scan4

Interface
- REQ-001 Parameter CLK_DIV, default 50000, SHALL set the clock cycles each digit is held active (1 kHz per digit at 50 MHz); legal range 2..2^20.
- REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
- REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
- REQ-004 data_in  input  16  SHALL carry four BCD/hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- REQ-005 load  input  1  SHALL be a one-cycle strobe requesting capture of data_in.
- REQ-006 bcd  output  4  SHALL be the nibble of the currently scanned digit, registered, feeding the downstream BCD-to-7-segment decoder.
- REQ-007 an  output  4  SHALL be the active-low anode enables, registered; bit n drives digit n.
- REQ-008 digit_sel  output  2  SHALL be the index (0..3) of the currently scanned digit.
- REQ-009 frame_tick  output  1  SHALL pulse high for one cycle when the scan wraps from digit 3 to digit 0.
- REQ-010 pending  output  1  SHALL be high while a captured value awaits commitment to the display.

Function
- REQ-011 A prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; its terminal count is the advance event.
- REQ-012 On each advance event digit_sel SHALL step 0->1->2->3->0; bcd and an SHALL reflect the new digit in the same cycle digit_sel changes.
- REQ-013 Exactly one an bit SHALL be low at any time (absent blanking, REQ-025); an SHALL be 1110, 1101, 1011, 0111 for digits 0..3.
- REQ-014 bcd SHALL equal the nibble of the committed display register selected by digit_sel.
- REQ-015 load high SHALL capture data_in into a shadow register and set pending on the next edge.
- REQ-016 On the advance event that wraps 3->0, with pending high, the shadow register SHALL be copied to the display register and pending cleared; the displayed value never changes mid-frame.
- REQ-017 load asserted in the same cycle as the 3->0 wrap SHALL commit data_in directly to the display register with pending low afterward.
- REQ-018 A second load while pending is high SHALL overwrite the shadow register; only the latest value is committed.
- REQ-019 frame_tick SHALL assert in the cycle digit_sel becomes 0 from 3, and at no other time.
- REQ-020 Latency from load to visible data SHALL be at most 4*CLK_DIV+1 cycles.

Reset
- REQ-021 While rst is low: prescaler=0, digit_sel=0, display and shadow registers=16'h0000, pending=0, frame_tick=0, bcd=4'h0, an=4'b1110.
- REQ-022 Reset asserted mid-scan or with pending high SHALL discard the pending value; after release scanning restarts at digit 0 with a full CLK_DIV period.
- REQ-023 load in the first cycle after reset release SHALL be honoured per REQ-015.

Configuration
- REQ-024 Macro LEAD_ZERO_BLANK_EN SHALL select leading-zero blanking.
- REQ-025 With LEAD_ZERO_BLANK_EN defined, a digit n>0 whose nibble and all higher nibbles in the display register are 0 SHALL have an=4'b1111 during its slot; digit 0 is never blanked. bcd and digit_sel timing are unchanged.
- REQ-026 Without LEAD_ZERO_BLANK_EN, all four digits SHALL always be enabled per REQ-013.

Verification (CLK_DIV=4)
- REQ-027 Reset, no load -> an cycles 1110,1101,1011,0111 every 4 clocks, bcd=0, frame_tick every 16 clocks.
- REQ-028 load data_in=16'h1234 mid-frame -> pending=1 until next wrap; then digits 0..3 show bcd 4,3,2,1; pending=0.
- REQ-029 load 16'hAAAA then 16'h5678 in same frame -> only 5678 is ever displayed.
- REQ-030 load 16'h9876 in the wrap cycle -> digit 0 immediately shows 6, pending never rises.
- REQ-031 rst low for 1 cycle during digit 2 with pending=1 -> an=1110, bcd=0, pending=0; old display value not restored.
- REQ-032 LEAD_ZERO_BLANK_EN defined, load 16'h0050 -> digits 3 and 2 an=1111, digit 1 shows 5, digit 0 shows 0; without macro all four enabled.
